// File: rtl/chacha_block_counter_gen.sv
// rtl/chacha_block_counter_gen.sv - multi-lane ChaCha20 block-counter generator with exhaustion detection
// Optional macro CHACHA_CTR_WRAP_EN selects legacy modulo wrap instead of exhaustion.
module chacha_block_counter_gen #(
  parameter int CTR_W    = 32,
  parameter int LANES    = 4,
  parameter int ISSUED_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [CTR_W-1:0]       load_value,
  input  logic                   enable,
  output logic                   ctr_valid,
  input  logic                   ctr_ready,
  output logic [LANES*CTR_W-1:0] ctr_out,
  output logic [LANES-1:0]       lane_mask,
  output logic                   exhausted,
  output logic [ISSUED_W-1:0]    blocks_issued
);

`ifdef CHACHA_CTR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_EXH  = 2'd2;

  logic [1:0]             state;
  logic [CTR_W-1:0]       base;
  logic                   handshake;
  logic [CTR_W:0]         base_adv;
  logic                   exhaust_hit;
  logic [CTR_W-1:0]       gen_base;
  logic [LANES*CTR_W-1:0] grp_data;
  logic [LANES-1:0]       grp_mask;
  logic [ISSUED_W:0]      legal_cnt;
  logic [ISSUED_W:0]      issued_sum;
  logic [ISSUED_W-1:0]    issued_next;

  assign handshake   = ctr_valid & ctr_ready;
  assign base_adv    = {1'b0, base} + (CTR_W+1)'(LANES);
  assign exhaust_hit = WRAP_EN ? 1'b0 : base_adv[CTR_W];
  // A back-to-back group is built from the post-handshake base.
  assign gen_base    = handshake ? base_adv[CTR_W-1:0] : base;

  always_comb begin
    logic [CTR_W:0] lane_sum;
    lane_sum = '0;
    grp_data = '0;
    grp_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = {1'b0, gen_base} + (CTR_W+1)'(i);
      grp_data[i*CTR_W +: CTR_W] = lane_sum[CTR_W-1:0];
      grp_mask[i] = WRAP_EN | ~lane_sum[CTR_W];
    end
  end

  always_comb begin
    legal_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      legal_cnt = legal_cnt + (ISSUED_W+1)'(lane_mask[i]);
    end
    issued_sum  = {1'b0, blocks_issued} + legal_cnt;
    issued_next = issued_sum[ISSUED_W] ? {ISSUED_W{1'b1}} : issued_sum[ISSUED_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      base          <= '0;
      ctr_valid     <= 1'b0;
      ctr_out       <= '0;
      lane_mask     <= '0;
      exhausted     <= 1'b0;
      blocks_issued <= '0;
    end else if (load) begin
      // A handshake in this cycle is consumed but deliberately not accounted.
      state         <= S_RUN;
      base          <= load_value;
      ctr_valid     <= 1'b0;
      exhausted     <= 1'b0;
      blocks_issued <= '0;
    end else begin
      case (state)
        S_IDLE: ;
        S_RUN: begin
          if (handshake) begin
            base          <= base_adv[CTR_W-1:0];
            blocks_issued <= issued_next;
            if (exhaust_hit) begin
              state     <= S_EXH;
              ctr_valid <= 1'b0;
              exhausted <= 1'b1;
            end else if (enable) begin
              ctr_valid <= 1'b1;
              ctr_out   <= grp_data;
              lane_mask <= grp_mask;
            end else begin
              ctr_valid <= 1'b0;
            end
          end else if (!ctr_valid && enable) begin
            ctr_valid <= 1'b1;
            ctr_out   <= grp_data;
            lane_mask <= grp_mask;
          end
        end
        S_EXH: ctr_valid <= 1'b0;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_counter_gen.sv
// tb/tb_chacha_block_counter_gen.sv - scoreboard bench for chacha_block_counter_gen (CTR_W=32, LANES=4)
module tb_chacha_block_counter_gen;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [31:0]  load_value;
  logic         enable;
  logic         ctr_valid;
  logic         ctr_ready;
  logic [127:0] ctr_out;
  logic [3:0]   lane_mask;
  logic         exhausted;
  logic [31:0]  blocks_issued;

  int checks = 0;
  int failures = 0;

  logic [127:0] exp_data_q[$];
  logic [3:0]   exp_mask_q[$];
  logic [127:0] exp_d;
  logic [3:0]   exp_m;

  chacha_block_counter_gen #(.CTR_W(32), .LANES(4), .ISSUED_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .enable(enable), .ctr_valid(ctr_valid), .ctr_ready(ctr_ready),
    .ctr_out(ctr_out), .lane_mask(lane_mask), .exhausted(exhausted),
    .blocks_issued(blocks_issued)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected group for a given base, pushed when stimulus is driven.
  task automatic push_group(input logic [31:0] b);
    logic [127:0] d;
    logic [3:0]   m;
    logic [32:0]  s;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, b} + 33'(i);
      d[i*32 +: 32] = s[31:0];
`ifdef CHACHA_CTR_WRAP_EN
      m[i] = 1'b1;
`else
      m[i] = ~s[32];
`endif
    end
    exp_data_q.push_back(d);
    exp_mask_q.push_back(m);
  endtask

  task automatic do_load(input logic [31:0] v);
    load = 1'b1;
    load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; load_value = '0; enable = 1'b1; ctr_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (ctr_valid !== 1'b0 || ctr_out !== '0 || lane_mask !== '0 || exhausted !== 1'b0 || blocks_issued !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b out=%h mask=%b exh=%b issued=%0d required all zero",
               ctr_valid, ctr_out, lane_mask, exhausted, blocks_issued);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (ctr_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_valid: cycle %0d ctr_valid=%b required 0", c, ctr_valid);
      end
    end
  endtask

  task automatic test_basic;
    int got = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    enable = 1'b1; ctr_ready = 1'b1;
    for (int g = 0; g < 3; g++) push_group(32'd1 + 32'(4*g));
    do_load(32'd1);
    checks++;
    if (ctr_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_load_gap: ctr_valid=%b required 0", ctr_valid);
    end
    for (int c = 0; c < 10 && got < 3; c++) begin
      step();
      if (ctr_valid && ctr_ready) begin
        exp_d = exp_data_q.pop_front();
        exp_m = exp_mask_q.pop_front();
        checks++;
        if (ctr_out !== exp_d || lane_mask !== exp_m) begin
          failures++;
          $display("FAIL basic_group%0d: out=%h mask=%b required out=%h mask=%b", got, ctr_out, lane_mask, exp_d, exp_m);
        end
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got++;
        if (got == 3) enable = 1'b0;
      end
    end
    checks++;
    if (got != 3 || last_cyc - first_cyc != 2) begin
      failures++;
      $display("FAIL basic_back_to_back: groups=%0d span=%0d required groups=3 span=2", got, last_cyc - first_cyc);
    end
    step();
    checks++;
    if (blocks_issued !== 32'd12 || ctr_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_issued: issued=%0d valid=%b required issued=12 valid=0", blocks_issued, ctr_valid);
    end
  endtask

  task automatic test_backpressure;
    exp_data_q.delete(); exp_mask_q.delete();
    enable = 1'b1; ctr_ready = 1'b1;
    for (int g = 0; g < 3; g++) push_group(32'd1 + 32'(4*g));
    do_load(32'd1);
    step();
    exp_d = exp_data_q.pop_front(); exp_m = exp_mask_q.pop_front();
    checks++;
    if (ctr_valid !== 1'b1 || ctr_out !== exp_d) begin
      failures++;
      $display("FAIL bp_first: valid=%b out=%h required valid=1 out=%h", ctr_valid, ctr_out, exp_d);
    end
    step();
    ctr_ready = 1'b0;
    exp_d = exp_data_q.pop_front(); exp_m = exp_mask_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ctr_valid !== 1'b1 || ctr_out !== exp_d || lane_mask !== exp_m || blocks_issued !== 32'd4) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b out=%h issued=%0d required valid=1 out=%h issued=4",
                 c, ctr_valid, ctr_out, blocks_issued, exp_d);
      end
      step();
    end
    ctr_ready = 1'b1;
    checks++;
    if (ctr_out !== exp_d) begin
      failures++;
      $display("FAIL bp_release: out=%h required %h", ctr_out, exp_d);
    end
    step();
    exp_d = exp_data_q.pop_front(); exp_m = exp_mask_q.pop_front();
    checks++;
    if (ctr_valid !== 1'b1 || ctr_out !== exp_d || blocks_issued !== 32'd8) begin
      failures++;
      $display("FAIL bp_next: valid=%b out=%h issued=%0d required valid=1 out=%h issued=8",
               ctr_valid, ctr_out, blocks_issued, exp_d);
    end
    enable = 1'b0;
    step();
    checks++;
    if (blocks_issued !== 32'd12) begin
      failures++;
      $display("FAIL bp_issued: issued=%0d required 12", blocks_issued);
    end
  endtask

  task automatic test_exhaustion;
    exp_data_q.delete(); exp_mask_q.delete();
    enable = 1'b1; ctr_ready = 1'b1;
    push_group(32'hFFFF_FFFE);
`ifdef CHACHA_CTR_WRAP_EN
    push_group(32'd2);
`endif
    do_load(32'hFFFF_FFFE);
    step();
    exp_d = exp_data_q.pop_front(); exp_m = exp_mask_q.pop_front();
    checks++;
    if (ctr_valid !== 1'b1 || ctr_out !== exp_d || lane_mask !== exp_m) begin
      failures++;
      $display("FAIL exh_group: valid=%b out=%h mask=%b required valid=1 out=%h mask=%b",
               ctr_valid, ctr_out, lane_mask, exp_d, exp_m);
    end
`ifdef CHACHA_CTR_WRAP_EN
    step();
    exp_d = exp_data_q.pop_front(); exp_m = exp_mask_q.pop_front();
    checks++;
    if (ctr_valid !== 1'b1 || ctr_out !== exp_d || lane_mask !== 4'hF || exhausted !== 1'b0) begin
      failures++;
      $display("FAIL wrap_group: valid=%b out=%h mask=%b exh=%b required valid=1 out=%h mask=1111 exh=0",
               ctr_valid, ctr_out, lane_mask, exhausted, exp_d);
    end
    enable = 1'b0;
    step();
    checks++;
    if (exhausted !== 1'b0 || blocks_issued !== 32'd8) begin
      failures++;
      $display("FAIL wrap_issued: exh=%b issued=%0d required exh=0 issued=8", exhausted, blocks_issued);
    end
`else
    checks++;
    if (lane_mask !== 4'b0011) begin
      failures++;
      $display("FAIL exh_mask: mask=%b required 0011", lane_mask);
    end
    step();
    checks++;
    if (exhausted !== 1'b1 || ctr_valid !== 1'b0 || blocks_issued !== 32'd2) begin
      failures++;
      $display("FAIL exh_state: exh=%b valid=%b issued=%0d required exh=1 valid=0 issued=2",
               exhausted, ctr_valid, blocks_issued);
    end
    repeat (3) step();
    checks++;
    if (ctr_valid !== 1'b0 || exhausted !== 1'b1) begin
      failures++;
      $display("FAIL exh_sticky: valid=%b exh=%b required valid=0 exh=1", ctr_valid, exhausted);
    end
`endif
  endtask

  task automatic test_boundary;
    exp_data_q.delete(); exp_mask_q.delete();
    enable = 1'b1; ctr_ready = 1'b1;
    push_group(32'hFFFF_FFFC);
    do_load(32'hFFFF_FFFC);
    step();
    exp_d = exp_data_q.pop_front(); exp_m = exp_mask_q.pop_front();
    checks++;
    if (ctr_valid !== 1'b1 || ctr_out !== exp_d || lane_mask !== 4'hF) begin
      failures++;
      $display("FAIL bnd_group: valid=%b out=%h mask=%b required valid=1 out=%h mask=1111",
               ctr_valid, ctr_out, lane_mask, exp_d);
    end
`ifdef CHACHA_CTR_WRAP_EN
    enable = 1'b0;
`endif
    step();
    checks++;
`ifdef CHACHA_CTR_WRAP_EN
    if (exhausted !== 1'b0 || ctr_valid !== 1'b0) begin
      failures++;
      $display("FAIL bnd_wrap: exh=%b valid=%b required exh=0 valid=0", exhausted, ctr_valid);
    end
    enable = 1'b1;
`else
    if (exhausted !== 1'b1 || ctr_valid !== 1'b0) begin
      failures++;
      $display("FAIL bnd_exh: exh=%b valid=%b required exh=1 valid=0", exhausted, ctr_valid);
    end
`endif
    push_group(32'd0);
    do_load(32'd0);
    checks++;
    if (exhausted !== 1'b0 || ctr_valid !== 1'b0 || blocks_issued !== 32'd0) begin
      failures++;
      $display("FAIL bnd_reload: exh=%b valid=%b issued=%0d required all 0", exhausted, ctr_valid, blocks_issued);
    end
    step();
    exp_d = exp_data_q.pop_front(); exp_m = exp_mask_q.pop_front();
    checks++;
    if (ctr_valid !== 1'b1 || ctr_out !== exp_d || lane_mask !== exp_m) begin
      failures++;
      $display("FAIL bnd_first: valid=%b out=%h required valid=1 out=%h", ctr_valid, ctr_out, exp_d);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    exp_data_q.delete(); exp_mask_q.delete();
    enable = 1'b1; ctr_ready = 1'b1;
    push_group(32'd1);
    do_load(32'd1);
    step();
    exp_d = exp_data_q.pop_front(); exp_m = exp_mask_q.pop_front();
    checks++;
    if (ctr_valid !== 1'b1 || ctr_out !== exp_d) begin
      failures++;
      $display("FAIL b2b_first: valid=%b out=%h required valid=1 out=%h", ctr_valid, ctr_out, exp_d);
    end
    push_group(32'd100);
    do_load(32'd100);
    checks++;
    if (ctr_valid !== 1'b0 || blocks_issued !== 32'd0) begin
      failures++;
      $display("FAIL b2b_load_hs: valid=%b issued=%0d required valid=0 issued=0", ctr_valid, blocks_issued);
    end
    step();
    exp_d = exp_data_q.pop_front(); exp_m = exp_mask_q.pop_front();
    checks++;
    if (ctr_valid !== 1'b1 || ctr_out !== exp_d) begin
      failures++;
      $display("FAIL b2b_reloaded: valid=%b out=%h required valid=1 out=%h", ctr_valid, ctr_out, exp_d);
    end
    enable = 1'b0;
    step();
    checks++;
    if (blocks_issued !== 32'd4) begin
      failures++;
      $display("FAIL b2b_issued: issued=%0d required 4", blocks_issued);
    end
  endtask

  task automatic test_midreset;
    exp_data_q.delete(); exp_mask_q.delete();
    enable = 1'b1; ctr_ready = 1'b1;
    do_load(32'h10);
    step();
    step();
    checks++;
    if (ctr_valid !== 1'b1 || ctr_out[31:0] !== 32'h14) begin
      failures++;
      $display("FAIL mid_running: valid=%b lane0=%h required valid=1 lane0=14", ctr_valid, ctr_out[31:0]);
    end
    rst_n = 1'b0;
    load = 1'b1;
    load_value = 32'h55;
    step();
    checks++;
    if (ctr_valid !== 1'b0 || ctr_out !== '0 || blocks_issued !== '0 || exhausted !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b out=%h issued=%0d required all zero", ctr_valid, ctr_out, blocks_issued);
    end
    rst_n = 1'b1;
    load = 1'b0;
    repeat (3) step();
    checks++;
    if (ctr_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_wins: valid=%b required 0", ctr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_exhaustion();
    test_boundary();
    test_back_to_back();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
